// File: rtl/hazard_pkg.sv
// Shared types and stall-length constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [1:0] LU_STALL       = 2'd1;
   localparam logic [1:0] BR_ALU_STALL   = 2'd1;
   localparam logic [1:0] BR_LD_EX_STALL = 2'd2;
   localparam logic [1:0] BR_LD_ME_STALL = 2'd1;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // A producer only matters if it writes a real register that ID actually reads.
   function automatic logic src_match(input logic [4:0] x,
                                      input logic [4:0] rs1, input logic use1,
                                      input logic [4:0] rs2, input logic use2);
      return (x != 5'd0) && (((x == rs1) && use1) || ((x == rs2) && use2));
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall-length calculation for the instruction sitting in ID.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [4:0] i_rs1_addr,
   input  logic [4:0] i_rs2_addr,
   input  logic       i_use_rs1,
   input  logic       i_use_rs2,
   input  logic       i_comp,
   input  logic       i_regwrite_ex,
   input  logic       i_memread_ex,
   input  logic [4:0] i_rd_addr_ex,
   input  logic       i_memread_me,
   input  logic [4:0] i_rd_addr_me,
   output logic [1:0] o_stall_n
);

   logic w_match_ex;
   logic w_match_me;

   assign w_match_ex = src_match(i_rd_addr_ex, i_rs1_addr, i_use_rs1, i_rs2_addr, i_use_rs2);
   assign w_match_me = src_match(i_rd_addr_me, i_rs1_addr, i_use_rs1, i_rs2_addr, i_use_rs2);

   // N is the largest requirement among all hazards that apply this cycle.
   always_comb begin
      // NOTE: default first so every path assigns o_stall_n and no latch is inferred.
      o_stall_n = 2'd0;
      if (i_comp && i_memread_ex && w_match_ex && (BR_LD_EX_STALL > o_stall_n))
         o_stall_n = BR_LD_EX_STALL;
      if (!i_comp && i_memread_ex && w_match_ex && (LU_STALL > o_stall_n))
         o_stall_n = LU_STALL;
      if (i_comp && i_regwrite_ex && !i_memread_ex && w_match_ex && (BR_ALU_STALL > o_stall_n))
         o_stall_n = BR_ALU_STALL;
      if (i_comp && i_memread_me && w_match_me && (BR_LD_ME_STALL > o_stall_n))
         o_stall_n = BR_LD_ME_STALL;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall FSM, stage enables/flushes and saturating perf counters.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [4:0]  rs1_addr_ID_i,
   input  logic [4:0]  rs2_addr_ID_i,
   input  logic        use_rs1_ID_i,
   input  logic        use_rs2_ID_i,
   input  logic        Branch_ID_i,
   input  logic        Jalr_ID_i,
   input  logic        BrTaken_ID_i,
   input  logic        RegWrite_EX_i,
   input  logic        MemRead_EX_i,
   input  logic [4:0]  rd_addr_EX_i,
   input  logic        MemRead_ME_i,
   input  logic [4:0]  rd_addr_ME_i,
   input  logic        dm_wait_i,
   output logic        PCWrite_o,
   output logic        IF_ID_Write_o,
   output logic        ID_EX_Write_o,
   output logic        EX_ME_Write_o,
   output logic        ME_WB_Write_o,
   output logic        IF_ID_Flush_o,
   output logic        ID_EX_Flush_o,
   output logic [15:0] stall_cycles_o,
   output logic [15:0] flush_count_o
);

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic [15:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   logic        w_comp;
   logic [1:0]  w_stall_n;
   logic        w_stall_cycle;
   logic        w_flush_cycle;
   logic [15:0] w_stall_next;
   logic [15:0] w_flush_next;

   assign w_comp = Branch_ID_i | Jalr_ID_i;

   hazard_detect u_detect (
      .i_rs1_addr    (rs1_addr_ID_i),
      .i_rs2_addr    (rs2_addr_ID_i),
      .i_use_rs1     (use_rs1_ID_i),
      .i_use_rs2     (use_rs2_ID_i),
      .i_comp        (w_comp),
      .i_regwrite_ex (RegWrite_EX_i),
      .i_memread_ex  (MemRead_EX_i),
      .i_rd_addr_ex  (rd_addr_EX_i),
      .i_memread_me  (MemRead_ME_i),
      .i_rd_addr_me  (rd_addr_ME_i),
      .o_stall_n     (w_stall_n)
   );

   // A pending multi-cycle stall keeps stalling even if the hazard inputs have moved on.
   assign w_stall_cycle = rstn_i && !dm_wait_i && ((r_state == STALL) || (w_stall_n != 2'd0));
   assign w_flush_cycle = rstn_i && !dm_wait_i && !w_stall_cycle && w_comp && BrTaken_ID_i;

   // Precedence: reset, then memory freeze, then stall, then normal run.
   always_comb begin
      PCWrite_o     = 1'b1;
      IF_ID_Write_o = 1'b1;
      ID_EX_Write_o = 1'b1;
      EX_ME_Write_o = 1'b1;
      ME_WB_Write_o = 1'b1;
      IF_ID_Flush_o = w_flush_cycle;
      ID_EX_Flush_o = 1'b0;
      if (!rstn_i) begin
         {PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_ME_Write_o, ME_WB_Write_o} = 5'b0;
         IF_ID_Flush_o = 1'b1;
         ID_EX_Flush_o = 1'b1;
      end else if (dm_wait_i) begin
         {PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_ME_Write_o, ME_WB_Write_o} = 5'b0;
         IF_ID_Flush_o = 1'b0;
      end else if (w_stall_cycle) begin
         PCWrite_o     = 1'b0;
         IF_ID_Write_o = 1'b0;
         ID_EX_Flush_o = 1'b1;
      end
   end

   assign w_stall_next = !rstn_i ? 16'd0 :
                         (w_stall_cycle && (r_stall_cycles != CNT_MAX)) ? r_stall_cycles + 16'd1 :
                         r_stall_cycles;
   assign w_flush_next = !rstn_i ? 16'd0 :
                         (w_flush_cycle && (r_flush_count != CNT_MAX)) ? r_flush_count + 16'd1 :
                         r_flush_count;

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_stall_cycles <= w_stall_next;
      r_flush_count  <= w_flush_next;
      if (!rstn_i) begin
         r_state <= RUN;
         r_cnt   <= 2'd0;
      end else if (!dm_wait_i) begin
         case (r_state)
            RUN: begin
               if (w_stall_n != 2'd0) begin
                  r_cnt   <= w_stall_n - 2'd1;
                  r_state <= (w_stall_n > 2'd1) ? STALL : RUN;
               end
            end
            STALL: begin
               r_cnt <= r_cnt - 2'd1;
               if (r_cnt == 2'd1)
                  r_state <= RUN;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign stall_cycles_o = r_stall_cycles;
   assign flush_count_o  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; inputs change on negedge, outputs checked 1ns later.
module tb_hazard_ctrl;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [4:0]  rs1_addr_ID_i, rs2_addr_ID_i;
   logic        use_rs1_ID_i, use_rs2_ID_i;
   logic        Branch_ID_i, Jalr_ID_i, BrTaken_ID_i;
   logic        RegWrite_EX_i, MemRead_EX_i;
   logic [4:0]  rd_addr_EX_i;
   logic        MemRead_ME_i;
   logic [4:0]  rd_addr_ME_i;
   logic        dm_wait_i;
   logic        PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_ME_Write_o, ME_WB_Write_o;
   logic        IF_ID_Flush_o, ID_EX_Flush_o;
   logic [15:0] stall_cycles_o, flush_count_o;

   int tests = 0;
   int fails = 0;

   // {PCWrite, IF_ID_Write, ID_EX_Write, EX_ME_Write, ME_WB_Write, IF_ID_Flush, ID_EX_Flush}
   localparam logic [6:0] V_RUN   = 7'b11111_00;
   localparam logic [6:0] V_FLUSH = 7'b11111_10;
   localparam logic [6:0] V_STALL = 7'b00111_01;
   localparam logic [6:0] V_FRZ   = 7'b00000_00;
   localparam logic [6:0] V_RST   = 7'b00000_11;

   logic [6:0] ctl;
   assign ctl = {PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_ME_Write_o, ME_WB_Write_o,
                 IF_ID_Flush_o, ID_EX_Flush_o};

   always #5 clk_i = ~clk_i;

   hazard_ctrl dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .rs1_addr_ID_i  (rs1_addr_ID_i),
      .rs2_addr_ID_i  (rs2_addr_ID_i),
      .use_rs1_ID_i   (use_rs1_ID_i),
      .use_rs2_ID_i   (use_rs2_ID_i),
      .Branch_ID_i    (Branch_ID_i),
      .Jalr_ID_i      (Jalr_ID_i),
      .BrTaken_ID_i   (BrTaken_ID_i),
      .RegWrite_EX_i  (RegWrite_EX_i),
      .MemRead_EX_i   (MemRead_EX_i),
      .rd_addr_EX_i   (rd_addr_EX_i),
      .MemRead_ME_i   (MemRead_ME_i),
      .rd_addr_ME_i   (rd_addr_ME_i),
      .dm_wait_i      (dm_wait_i),
      .PCWrite_o      (PCWrite_o),
      .IF_ID_Write_o  (IF_ID_Write_o),
      .ID_EX_Write_o  (ID_EX_Write_o),
      .EX_ME_Write_o  (EX_ME_Write_o),
      .ME_WB_Write_o  (ME_WB_Write_o),
      .IF_ID_Flush_o  (IF_ID_Flush_o),
      .ID_EX_Flush_o  (ID_EX_Flush_o),
      .stall_cycles_o (stall_cycles_o),
      .flush_count_o  (flush_count_o)
   );

   task automatic idle_inputs();
      rs1_addr_ID_i = 5'd0; rs2_addr_ID_i = 5'd0;
      use_rs1_ID_i = 1'b0;  use_rs2_ID_i = 1'b0;
      Branch_ID_i = 1'b0;   Jalr_ID_i = 1'b0; BrTaken_ID_i = 1'b0;
      RegWrite_EX_i = 1'b0; MemRead_EX_i = 1'b0; rd_addr_EX_i = 5'd0;
      MemRead_ME_i = 1'b0;  rd_addr_ME_i = 5'd0;
      dm_wait_i = 1'b0;
   endtask

   // Advance one clock and return to the next negedge for driving.
   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn_i = 1'b0;
      step();
      rstn_i = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn_i = 1'b0;
      #1;
      tests++; if (ctl !== V_RST) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, V_RST); end
      step();
      tests++; if (stall_cycles_o !== 16'd0) begin fails++; $display("FAIL reset_stall got %h want 0", stall_cycles_o); end
      tests++; if (flush_count_o !== 16'd0) begin fails++; $display("FAIL reset_flush got %h want 0", flush_count_o); end
      rstn_i = 1'b1;
      #1;
      tests++; if (ctl !== V_RUN) begin fails++; $display("FAIL reset_run got %b want %b", ctl, V_RUN); end
   endtask

   task automatic test_load_use();
      do_reset();
      MemRead_EX_i = 1'b1; rd_addr_EX_i = 5'd5; RegWrite_EX_i = 1'b1;
      rs1_addr_ID_i = 5'd5; use_rs1_ID_i = 1'b1;
      #1;
      tests++; if (ctl !== V_STALL) begin fails++; $display("FAIL lu_stall got %b want %b", ctl, V_STALL); end
      step();
      MemRead_EX_i = 1'b0; rd_addr_EX_i = 5'd0; RegWrite_EX_i = 1'b0;
      MemRead_ME_i = 1'b1; rd_addr_ME_i = 5'd5;
      #1;
      tests++; if (ctl !== V_RUN) begin fails++; $display("FAIL lu_release got %b want %b", ctl, V_RUN); end
      tests++; if (stall_cycles_o !== 16'd1) begin fails++; $display("FAIL lu_count got %0d want 1", stall_cycles_o); end
   endtask

   task automatic test_branch_load();
      do_reset();
      MemRead_EX_i = 1'b1; rd_addr_EX_i = 5'd7; RegWrite_EX_i = 1'b1;
      rs1_addr_ID_i = 5'd1; rs2_addr_ID_i = 5'd7; use_rs1_ID_i = 1'b1; use_rs2_ID_i = 1'b1;
      Branch_ID_i = 1'b1; BrTaken_ID_i = 1'b1;
      #1;
      tests++; if (ctl !== V_STALL) begin fails++; $display("FAIL brld_stall1 got %b want %b", ctl, V_STALL); end
      step();
      MemRead_EX_i = 1'b0; rd_addr_EX_i = 5'd0; RegWrite_EX_i = 1'b0;
      MemRead_ME_i = 1'b1; rd_addr_ME_i = 5'd7;
      #1;
      tests++; if (ctl !== V_STALL) begin fails++; $display("FAIL brld_stall2 got %b want %b", ctl, V_STALL); end
      step();
      MemRead_ME_i = 1'b0; rd_addr_ME_i = 5'd0;
      #1;
      tests++; if (ctl !== V_FLUSH) begin fails++; $display("FAIL brld_flush got %b want %b", ctl, V_FLUSH); end
      step();
      idle_inputs();
      #1;
      tests++; if (ctl !== V_RUN) begin fails++; $display("FAIL brld_after got %b want %b", ctl, V_RUN); end
      tests++; if (stall_cycles_o !== 16'd2) begin fails++; $display("FAIL brld_stalls got %0d want 2", stall_cycles_o); end
      tests++; if (flush_count_o !== 16'd1) begin fails++; $display("FAIL brld_flushes got %0d want 1", flush_count_o); end
   endtask

   task automatic test_jalr_alu();
      do_reset();
      RegWrite_EX_i = 1'b1; rd_addr_EX_i = 5'd3;
      rs1_addr_ID_i = 5'd3; use_rs1_ID_i = 1'b1; Jalr_ID_i = 1'b1; BrTaken_ID_i = 1'b1;
      #1;
      tests++; if (ctl !== V_STALL) begin fails++; $display("FAIL jalr_stall got %b want %b", ctl, V_STALL); end
      step();
      RegWrite_EX_i = 1'b0; rd_addr_EX_i = 5'd0;
      #1;
      tests++; if (ctl !== V_FLUSH) begin fails++; $display("FAIL jalr_flush got %b want %b", ctl, V_FLUSH); end
      step();
      idle_inputs();
      #1;
      tests++; if (stall_cycles_o !== 16'd1) begin fails++; $display("FAIL jalr_stalls got %0d want 1", stall_cycles_o); end
      tests++; if (flush_count_o !== 16'd1) begin fails++; $display("FAIL jalr_flushes got %0d want 1", flush_count_o); end
   endtask

   task automatic test_x0();
      do_reset();
      MemRead_EX_i = 1'b1; RegWrite_EX_i = 1'b1; rd_addr_EX_i = 5'd0;
      use_rs1_ID_i = 1'b1; use_rs2_ID_i = 1'b1; Branch_ID_i = 1'b1;
      #1;
      tests++; if (ctl !== V_RUN) begin fails++; $display("FAIL x0_nostall got %b want %b", ctl, V_RUN); end
      step();
      tests++; if (stall_cycles_o !== 16'd0) begin fails++; $display("FAIL x0_count got %0d want 0", stall_cycles_o); end
      idle_inputs();
   endtask

   task automatic test_dm_wait();
      do_reset();
      MemRead_EX_i = 1'b1; rd_addr_EX_i = 5'd7; RegWrite_EX_i = 1'b1;
      rs2_addr_ID_i = 5'd7; use_rs2_ID_i = 1'b1; Branch_ID_i = 1'b1; BrTaken_ID_i = 1'b1;
      #1;
      tests++; if (ctl !== V_STALL) begin fails++; $display("FAIL dm_first got %b want %b", ctl, V_STALL); end
      step();
      MemRead_EX_i = 1'b0; rd_addr_EX_i = 5'd0; RegWrite_EX_i = 1'b0;
      MemRead_ME_i = 1'b1; rd_addr_ME_i = 5'd7;
      dm_wait_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (ctl !== V_FRZ) begin fails++; $display("FAIL dm_freeze%0d got %b want %b", i, ctl, V_FRZ); end
         step();
      end
      tests++; if (stall_cycles_o !== 16'd1) begin fails++; $display("FAIL dm_hold got %0d want 1", stall_cycles_o); end
      dm_wait_i = 1'b0;
      #1;
      tests++; if (ctl !== V_STALL) begin fails++; $display("FAIL dm_resume got %b want %b", ctl, V_STALL); end
      step();
      MemRead_ME_i = 1'b0; rd_addr_ME_i = 5'd0;
      #1;
      tests++; if (ctl !== V_FLUSH) begin fails++; $display("FAIL dm_flush got %b want %b", ctl, V_FLUSH); end
      tests++; if (stall_cycles_o !== 16'd2) begin fails++; $display("FAIL dm_total got %0d want 2", stall_cycles_o); end
      step();
      idle_inputs();
   endtask

   task automatic test_saturate();
      logic [15:0] exp_cnt [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
      do_reset();
      dm_wait_i = 1'b1;
      force dut.r_stall_cycles = 16'hFFFE;
      step();
      release dut.r_stall_cycles;
      dm_wait_i = 1'b0;
      #1;
      tests++; if (stall_cycles_o !== 16'hFFFE) begin fails++; $display("FAIL sat_preload got %h want FFFE", stall_cycles_o); end
      for (int i = 0; i < 3; i++) begin
         // Two load-use stalls, then a branch-on-load that leaves the FSM in STALL.
         MemRead_EX_i = 1'b1; rd_addr_EX_i = 5'd9; rs1_addr_ID_i = 5'd9; use_rs1_ID_i = 1'b1;
         Branch_ID_i = (i == 2);
         step();
         tests++; if (stall_cycles_o !== exp_cnt[i]) begin fails++; $display("FAIL sat_cnt%0d got %h want %h", i, stall_cycles_o, exp_cnt[i]); end
      end
      idle_inputs();
      rstn_i = 1'b0;
      #1;
      tests++; if (ctl !== V_RST) begin fails++; $display("FAIL sat_rst_ctl got %b want %b", ctl, V_RST); end
      step();
      rstn_i = 1'b1;
      #1;
      tests++; if (stall_cycles_o !== 16'd0) begin fails++; $display("FAIL sat_rst_cnt got %h want 0", stall_cycles_o); end
      tests++; if (ctl !== V_RUN) begin fails++; $display("FAIL sat_rst_run got %b want %b", ctl, V_RUN); end
   endtask

   initial begin
      idle_inputs();
      rstn_i = 1'b0;
      @(negedge clk_i);
      test_reset();
      test_load_use();
      test_branch_load();
      test_jalr_alu();
      test_x0();
      test_dm_wait();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports in this order: clk_i in 1, pipeline clock; rstn_i in 1, synchronous active-low reset, sampled on the rising edge of clk_i. One clock domain only.
REQ-002 SHALL have inputs rs1_addr_ID_i and rs2_addr_ID_i (5 bits each): ID-stage source register addresses.
REQ-003 SHALL have inputs use_rs1_ID_i and use_rs2_ID_i (1 bit each): the ID instruction reads that source.
REQ-004 SHALL have inputs Branch_ID_i and Jalr_ID_i (1 bit each): the ID instruction resolves a branch or JALR in ID.
REQ-005 SHALL have input BrTaken_ID_i (1 bit): the branch is taken or the JALR redirects, valid when Branch_ID_i or Jalr_ID_i is high.
REQ-006 SHALL have inputs RegWrite_EX_i and MemRead_EX_i (1 bit each) and rd_addr_EX_i (5 bits): EX-stage writeback info.
REQ-007 SHALL have inputs MemRead_ME_i (1 bit) and rd_addr_ME_i (5 bits): ME-stage load info.
REQ-008 SHALL have input dm_wait_i (1 bit): the data SRAM is not ready; the whole pipeline must freeze.
REQ-009 SHALL have outputs PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_ME_Write_o and ME_WB_Write_o (1 bit each): stage register enables.
REQ-010 SHALL have outputs IF_ID_Flush_o and ID_EX_Flush_o (1 bit each): insert a bubble into that register.
REQ-011 SHALL have outputs stall_cycles_o and flush_count_o (16 bits each): saturating performance counters.

Function
REQ-012 SHALL define match(x) as: x != 0 and ((x == rs1_addr_ID_i and use_rs1_ID_i) or (x == rs2_addr_ID_i and use_rs2_ID_i)).
REQ-013 SHALL define comp = Branch_ID_i or Jalr_ID_i.
REQ-014 SHALL compute the stall length N each cycle as the maximum of these terms, 0 if none applies:
  - 2 when comp and MemRead_EX_i and match(rd_addr_EX_i);
  - 1 when not comp and MemRead_EX_i and match(rd_addr_EX_i);
  - 1 when comp and RegWrite_EX_i and not MemRead_EX_i and match(rd_addr_EX_i);
  - 1 when comp and MemRead_ME_i and match(rd_addr_ME_i).
REQ-015 SHALL implement an FSM with states RUN and STALL and a 2-bit counter cnt.
REQ-016 SHALL act in RUN with N > 0 and dm_wait_i = 0 as follows: stall outputs this cycle, cnt <= N-1, next state STALL if N-1 > 0, otherwise RUN.
REQ-017 SHALL act in STALL with dm_wait_i = 0 as follows: stall outputs, cnt <= cnt-1, and return to RUN when cnt == 1.
REQ-018 SHALL drive the stall outputs as: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1, IF_ID_Flush_o=0; all other enables = 1.
REQ-019 SHALL, in RUN with N == 0 and dm_wait_i = 0, drive all enables to 1 and ID_EX_Flush_o to 0, and set IF_ID_Flush_o = comp and BrTaken_ID_i.
REQ-020 SHALL NOT assert IF_ID_Flush_o during a stall cycle; the branch resolves in the first non-stall cycle.
REQ-021 SHALL, when dm_wait_i = 1, drive all five enables to 0 and both flushes to 0, hold state and cnt, and not update counters. This has priority over all stall and flush logic.
REQ-022 SHALL have stall_cycles_o increment by 1 in every stall cycle with dm_wait_i = 0, saturating at 16'hFFFF.
REQ-023 SHALL have flush_count_o increment by 1 in every cycle IF_ID_Flush_o = 1, saturating at 16'hFFFF.
REQ-024 SHALL evaluate hazards combinationally in the same cycle (zero latency); state and counters update on the next clock edge.

Reset
REQ-025 SHALL, while rstn_i = 0, drive all enables to 0 and both flushes to 1.
REQ-026 SHALL, on the edge where rstn_i = 0, set state <= RUN, cnt <= 0, stall_cycles_o <= 0 and flush_count_o <= 0.
REQ-027 SHALL give reset asserted mid-stall priority: the FSM returns to RUN and the pending stall is abandoned.

Structure
REQ-028 SHALL place in package hazard_pkg: the state enum (RUN, STALL) and constants LU_STALL=1, BR_ALU_STALL=1, BR_LD_EX_STALL=2, BR_LD_ME_STALL=1.
REQ-029 SHALL compute N in a sub-module hazard_detect (combinational); hazard_ctrl holds the FSM, cnt and counters.

Verification
REQ-030 SHALL cover: load x5 in EX, ID add uses rs1=x5 -> exactly 1 stall cycle (PCWrite_o=0, ID_EX_Flush_o=1), then RUN; stall_cycles_o=1.
REQ-031 SHALL cover: load x7 in EX, ID beq uses rs2=x7, taken -> 2 stall cycles, then IF_ID_Flush_o=1 for 1 cycle; stall_cycles_o=2, flush_count_o=1.
REQ-032 SHALL cover: addi x3 in EX (RegWrite), ID jalr rs1=x3 -> 1 stall cycle, then a flush.
REQ-033 SHALL cover: rd_addr_EX_i=0 with MemRead, ID uses x0 -> no stall.
REQ-034 SHALL cover: dm_wait_i=1 for 3 cycles during the second cycle of a 2-cycle stall -> all enables 0, then the remaining stall cycle completes; total stall_cycles_o=2.
REQ-035 SHALL cover: preload stall_cycles_o at 16'hFFFE, force 3 stall cycles -> holds at 16'hFFFF; then rstn_i=0 for 1 cycle -> 0, state RUN.
